// File: rtl/button_cmd_pkg.sv
// Shared types and constants for the push-button command encoder.
package button_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RIGHT,
    LEFT,
    PAUSE,
    RESET
  } state_e;

  localparam logic [3:0] CMD_IDLE  = 4'b0000;
  localparam logic [3:0] CMD_RST   = 4'b0001;
  localparam logic [3:0] CMD_RIGHT = 4'b0010;
  localparam logic [3:0] CMD_LEFT  = 4'b0100;
  localparam logic [3:0] CMD_PAUSE = 4'b1000;

  localparam int BTN_RST   = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_PAUSE = 3;

  function automatic logic [3:0] state_cmd(input state_e s);
    logic [3:0] c;
    c = CMD_IDLE;
    case (s)
      RIGHT:   c = CMD_RIGHT;
      LEFT:    c = CMD_LEFT;
      PAUSE:   c = CMD_PAUSE;
      RESET:   c = CMD_RST;
      default: c = CMD_IDLE;
    endcase
    return c;
  endfunction

  // The RESET state reports the IDLE code on the mode bus.
  function automatic logic [1:0] state_mode(input state_e s);
    logic [1:0] m;
    m = 2'd0;
    case (s)
      RIGHT:   m = 2'd1;
      LEFT:    m = 2'd2;
      PAUSE:   m = 2'd3;
      default: m = 2'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-count debouncer and registered rising-edge pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic          db_prev_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      rise_q    <= db_q & ~db_prev_q;
      cnt_q     <= cnt_d;
    end
  end

  assign level = db_q;
  assign rise  = rise_q;

endmodule

// File: rtl/button_cmd_encoder.sv
// Turns four raw push-buttons into the latched one-hot command bus for the LED shifter.
module button_cmd_encoder
  import button_cmd_pkg::*;
#(
  parameter int DB_CYCLES  = 500000,
  parameter int RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button,
  output logic [3:0] cmd,
  output logic [1:0] mode,
  output logic       cmd_event
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0] RCNT_LOAD = RW'(RST_CYCLES - 1);

  logic [3:0]    rise_w;
  logic [3:0]    level_w;
  logic [3:0]    press_w;

  state_e        state_q;
  state_e        state_d;
  logic [RW-1:0] rcnt_q;
  logic [RW-1:0] rcnt_d;
  logic [3:0]    cmd_q;
  logic [3:0]    cmd_d;
  logic [1:0]    mode_q;
  logic [1:0]    mode_d;
  logic          event_q;
  logic          event_d;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (button[gi]),
        .level(level_w[gi]),
        .rise (rise_w[gi])
      );
    end
  endgenerate

  // A press is only taken while its debounced level is still asserted.
  assign press_w = rise_w & level_w;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    event_d = 1'b0;
    if (press_w[BTN_RST]) begin
      state_d = RESET;
      rcnt_d  = RCNT_LOAD;
      event_d = 1'b1;
    end else begin
      case (state_q)
        RESET: begin
          if (rcnt_q == '0) begin
            state_d = IDLE;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
        default: begin
          if (press_w[BTN_PAUSE]) begin
            state_d = PAUSE;
            event_d = 1'b1;
          end else if (press_w[BTN_LEFT]) begin
            state_d = LEFT;
            event_d = 1'b1;
          end else if (press_w[BTN_RIGHT]) begin
            state_d = RIGHT;
            event_d = 1'b1;
          end
        end
      endcase
    end
    cmd_d  = state_cmd(state_d);
    mode_d = state_mode(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      cmd_q   <= CMD_IDLE;
      mode_q  <= 2'd0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      event_q <= event_d;
    end
  end

  assign cmd       = cmd_q;
  assign mode      = mode_q;
  assign cmd_event = event_q;

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Directed bench for button_cmd_encoder with a cycle-level behavioural model of the button front end.
module tb_button_cmd_encoder;

  localparam int DB      = 4;
  localparam int RC      = 2;
  localparam int RC_LONG = 12;

  logic       clk;
  logic       rst;
  logic [3:0] button;
  logic [3:0] cmd;
  logic [1:0] mode;
  logic       cmd_event;
  logic [3:0] cmd2;
  logic [1:0] mode2;
  logic       cmd_event2;

  int checks = 0;
  int errors = 0;
  int ev_count;

  button_cmd_encoder #(.DB_CYCLES(DB), .RST_CYCLES(RC)) u_dut (
    .clk(clk), .rst(rst), .button(button),
    .cmd(cmd), .mode(mode), .cmd_event(cmd_event)
  );

  // Second instance with a long reset window so a reset restart is observable.
  button_cmd_encoder #(.DB_CYCLES(DB), .RST_CYCLES(RC_LONG)) u_dut_long (
    .clk(clk), .rst(rst), .button(button),
    .cmd(cmd2), .mode(mode2), .cmd_event(cmd_event2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (short-window instance) ----------------
  typedef struct packed {
    logic [1:0] mode;
    logic       in_rst;
    logic [7:0] left;
    logic       ev;
  } mstate_t;

  logic [63:0] hist_q;          // raw samples, newest in the low nibble
  logic [3:0]  lvl_q;           // accepted levels
  logic [3:0]  acc1_q, acc2_q;  // accepted rises, one and two edges old
  mstate_t     ms_q;
  logic [7:0]  dbs;

  // A level is accepted once the last DB synchronised samples (raw delayed by
  // two clocks) all agree and differ from the current level.
  function automatic logic [7:0] db_step(input logic [63:0] h, input logic [3:0] lvl);
    logic [3:0] nl;
    logic [3:0] r;
    logic       same;
    nl = lvl;
    r  = '0;
    for (int b = 0; b < 4; b++) begin
      same = 1'b1;
      for (int j = 2; j <= DB + 1; j++) begin
        if (h[4*j+b] != h[8+b]) same = 1'b0;
      end
      if (same && (h[8+b] != lvl[b])) begin
        nl[b] = h[8+b];
        r[b]  = h[8+b];
      end
    end
    return {nl, r};
  endfunction

  function automatic mstate_t fsm_step(input mstate_t s, input logic [3:0] r);
    mstate_t n;
    n    = s;
    n.ev = 1'b0;
    if (r[0]) begin
      n.in_rst = 1'b1;
      n.left   = 8'(RC);
      n.mode   = 2'd0;
      n.ev     = 1'b1;
    end else if (s.in_rst) begin
      n.left = s.left - 8'd1;
      if (n.left == 8'd0) n.in_rst = 1'b0;
    end else if (r[3]) begin
      n.mode = 2'd3;
      n.ev   = 1'b1;
    end else if (r[2]) begin
      n.mode = 2'd2;
      n.ev   = 1'b1;
    end else if (r[1]) begin
      n.mode = 2'd1;
      n.ev   = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [3:0] model_cmd(input mstate_t s);
    if (s.in_rst) return 4'b0001;
    if (s.mode == 2'd0) return 4'b0000;
    return 4'(1 << s.mode);
  endfunction

  function automatic logic [1:0] model_mode(input mstate_t s);
    return s.in_rst ? 2'd0 : s.mode;
  endfunction

  assign dbs = db_step({hist_q[59:0], button}, lvl_q);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      lvl_q  <= '0;
      acc1_q <= '0;
      acc2_q <= '0;
      ms_q   <= '0;
    end else begin
      hist_q <= {hist_q[59:0], button};
      lvl_q  <= dbs[7:4];
      acc1_q <= dbs[3:0];
      acc2_q <= acc1_q;
      ms_q   <= fsm_step(ms_q, acc2_q);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model cmd",   int'(cmd),       int'(model_cmd(ms_q)));
    chk("model mode",  int'(mode),      int'(model_mode(ms_q)));
    chk("model event", int'(cmd_event), int'(ms_q.ev));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  initial begin
    rst    = 1'b1;
    button = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset cmd",   int'(cmd),       'b0000);
    chk("reset mode",  int'(mode),      0);
    chk("reset event", int'(cmd_event), 0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle with right held, then latency after release.
    button = 4'b0010;
    cyc(10);
    chk("right before rst", int'(cmd), 'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async rst cmd",  int'(cmd),  'b0000);
    chk("async rst mode", int'(mode), 0);
    chk("async rst cmd2", int'(cmd2), 'b0000);
    cyc(2);
    rst = 1'b0;
    cyc(7);
    chk("rst release +6 cmd", int'(cmd), 'b0000);
    cyc(1);
    chk("rst release +7 cmd",   int'(cmd),       'b0010);
    chk("rst release +7 mode",  int'(mode),      1);
    chk("rst release +7 event", int'(cmd_event), 1);
    $display("phase async-reset done at %0t", $time);

    // Glitches shorter than the debounce window, then a clean hold.
    rst    = 1'b1;
    button = 4'b0000;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    for (int r = 0; r < 5; r++) begin
      button = 4'b0010;
      cyc(3);
      chk("glitch cmd", int'(cmd), 'b0000);
      button = 4'b0000;
      cyc(3);
    end
    button = 4'b0010;
    cyc(7);
    chk("debounce +6 cmd", int'(cmd), 'b0000);
    cyc(1);
    chk("debounce +7 cmd",   int'(cmd),       'b0010);
    chk("debounce +7 event", int'(cmd_event), 1);
    cyc(1);
    chk("debounce +8 event", int'(cmd_event), 0);
    $display("phase debounce done at %0t", $time);

    // Mode sequence right -> left -> pause, latched after release.
    button = 4'b0000; cyc(10);
    button = 4'b0010; cyc(10);
    chk("seq right cmd", int'(cmd), 'b0010);
    chk("seq right mode", int'(mode), 1);
    button = 4'b0000; cyc(10);
    button = 4'b0100; cyc(10);
    chk("seq left cmd", int'(cmd), 'b0100);
    chk("seq left mode", int'(mode), 2);
    button = 4'b1000; cyc(10);
    chk("seq pause cmd", int'(cmd), 'b1000);
    chk("seq pause mode", int'(mode), 3);
    button = 4'b0000; cyc(10);
    chk("seq released cmd", int'(cmd), 'b1000);
    $display("phase mode-sequence done at %0t", $time);

    // Priority between simultaneous presses.
    button = 4'b0010; cyc(10);
    chk("prio start right", int'(cmd), 'b0010);
    button = 4'b0000; cyc(10);
    button = 4'b1110; cyc(10);
    chk("prio 1110 cmd", int'(cmd), 'b1000);
    button = 4'b0000; cyc(10);
    button = 4'b1111; cyc(8);
    chk("prio 1111 cmd c1", int'(cmd), 'b0001);
    chk("prio 1111 mode c1", int'(mode), 0);
    cyc(1);
    chk("prio 1111 cmd c2", int'(cmd), 'b0001);
    cyc(1);
    chk("prio 1111 cmd end", int'(cmd), 'b0000);
    chk("prio 1111 mode end", int'(mode), 0);
    $display("phase priority done at %0t", $time);

    // Reset restart (long-window instance) and a right press dropped in RESET.
    button = 4'b0000; cyc(20);
    chk("restart pre cmd2", int'(cmd2), 'b0000);
    button = 4'b0001; cyc(2);
    button = 4'b0011; cyc(2);
    button = 4'b0010; cyc(4);
    chk("restart first cmd",   int'(cmd),        'b0001);
    chk("restart first event", int'(cmd_event),  1);
    chk("restart first cmd2",  int'(cmd2),       'b0001);
    button = 4'b0011;
    cyc(2);
    chk("dropped right cmd",    int'(cmd),        'b0000);
    chk("dropped right event",  int'(cmd_event),  0);
    chk("dropped right cmd2",   int'(cmd2),       'b0001);
    chk("dropped right event2", int'(cmd_event2), 0);
    cyc(6);
    chk("restart second cmd",    int'(cmd),        'b0001);
    chk("restart second event2", int'(cmd_event2), 1);
    cyc(5);
    chk("restart extended cmd2", int'(cmd2), 'b0001);
    cyc(6);
    chk("restart last cmd2", int'(cmd2), 'b0001);
    cyc(1);
    chk("restart end cmd2",  int'(cmd2),  'b0000);
    chk("restart end mode2", int'(mode2), 0);
    $display("phase reset-restart done at %0t", $time);

    // Long hold produces a single event and the mode stays latched.
    button = 4'b0000; cyc(12);
    button   = 4'b0100;
    ev_count = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (cmd_event) ev_count++;
    end
    chk("hold event count", ev_count, 1);
    chk("hold cmd", int'(cmd), 'b0100);
    button = 4'b0000; cyc(10);
    chk("hold released cmd",  int'(cmd),  'b0100);
    chk("hold released mode", int'(mode), 2);
    $display("phase hold done at %0t", $time);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
